nes_controller_responder: RTL and testbench



---
 rtl/nes_controller_responder_if.sv | 21 ++
 rtl/nes_controller_responder.sv | 123 ++++++++++++
 tb/tb_nes_controller_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/nes_controller_responder_if.sv
// Pad-side bus of the NES/SNES serial protocol: console strobes plus
// board-side button word, mode select and frame status.
interface nes_controller_responder_if;
  logic        nes_latch;
  logic        nes_clk;
  logic [11:0] buttons;
  logic        snes_mode;
  logic        nes_data;
  logic        busy;
  logic        frame_done;

  // master drives the console strobes and the button word; slave is the pad
  modport master (
    output nes_latch, nes_clk, buttons, snes_mode,
    input  nes_data, busy, frame_done
  );
  modport slave (
    input  nes_latch, nes_clk, buttons, snes_mode,
    output nes_data, busy, frame_done
  );
endinterface

// File: rtl/nes_controller_responder.sv
// 4021-style game pad emulator: parallel-loads buttons while latch is high,
// then shifts one active-low bit per synchronized console clock rising edge.
module nes_controller_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nes_controller_responder_if.slave     bus,
  output logic [1:0]                    dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, clk_sync_q;
  logic                   latch_prev_q, clk_prev_q;
  logic [15:0]            sr_q, sr_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic        latch_s, clk_s;
  logic        latch_rise, latch_fall, clk_rise;
  logic [15:0] frame_word;
  logic [4:0]  n_last, n_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], bus.nes_latch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], bus.nes_clk};
      latch_prev_q <= latch_s;
      clk_prev_q   <= clk_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign clk_rise   = clk_s & ~clk_prev_q;

  // Line levels, bit 0 first. NES: A,B,Sel,Start,Up,Down,Left,Right. SNES ID nibble reads as 1s.
  assign frame_word = bus.snes_mode ? {4'hF, ~bus.buttons}
                                    : {8'h00, ~bus.buttons[7:2], ~bus.buttons[0], ~bus.buttons[8]};

  // Bit 0 is already on the line after the load, so the last bit is out once N-1 edges arrive.
  assign n_last = mode_q ? 5'd15 : 5'd7;
  assign n_full = mode_q ? 5'd16 : 5'd8;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (latch_rise) begin
      state_d = LOAD;
      sr_d    = frame_word;
      cnt_d   = 5'd0;
      mode_d  = bus.snes_mode;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          // transparent load; clock edges are ignored, so a coincident clock edge never skips bit 0
          sr_d   = frame_word;
          mode_d = bus.snes_mode;
          cnt_d  = 5'd0;
          if (latch_fall) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            sr_d  = {1'b0, sr_q[15:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q + 5'd1 == n_last) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          // grounded serial input: extra edges shift in zeros
          if (clk_rise) begin
            sr_d  = {1'b0, sr_q[15:1]};
            cnt_d = (cnt_q == n_full) ? cnt_q : cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= 16'hFFFF;
      cnt_q   <= 5'd0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.nes_data   = sr_q[0];
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed bench for the pad emulator: drives console latch/clock pins
// slowly relative to clk and checks the serial line, busy and frame_done.
module tb_nes_controller_responder;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad   = 0;
  int         fd_cnt = 0;
  int         fd_base;
  logic [7:0]  nes_exp;
  logic [15:0] snes_exp;

  nes_controller_responder_if bus();

  nes_controller_responder #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic latch_rise();
    bus.nes_latch = 1'b1;
    wait_cyc(8);
  endtask

  task automatic latch_drop();
    bus.nes_latch = 1'b0;
    wait_cyc(5);
  endtask

  task automatic clk_edge();
    bus.nes_clk = 1'b1;
    wait_cyc(5);
    bus.nes_clk = 1'b0;
    wait_cyc(5);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.nes_latch = 1'b0;
    bus.nes_clk   = 1'b0;
    bus.buttons   = 12'h000;
    bus.snes_mode = 1'b0;
    wait_cyc(3);
    chk("rst_data", 16'(bus.nes_data), 16'd1);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.frame_done), 16'd0);
    chk("rst_state", 16'(dbg_state), 16'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // NES frame, A and B pressed
    bus.buttons = 12'h101;
    nes_exp = 8'b1111_1100;
    fd_base = fd_cnt;
    latch_rise();
    chk("nes_latch_data", 16'(bus.nes_data), 16'd0);
    chk("nes_latch_busy", 16'(bus.busy), 16'd1);
    chk("nes_latch_state", 16'(dbg_state), 16'd1);
    latch_drop();
    chk("nes_bit0", 16'(bus.nes_data), 16'(nes_exp[0]));
    for (int i = 1; i < 8; i++) begin
      clk_edge();
      chk($sformatf("nes_bit%0d", i), 16'(bus.nes_data), 16'(nes_exp[i]));
      chk($sformatf("nes_fd%0d", i), 16'(fd_cnt - fd_base), (i == 7) ? 16'd1 : 16'd0);
      chk($sformatf("nes_busy%0d", i), 16'(bus.busy), (i == 7) ? 16'd0 : 16'd1);
    end
    chk("nes_state_done", 16'(dbg_state), 16'd3);
    for (int i = 8; i < 10; i++) begin
      clk_edge();
      chk($sformatf("nes_extra%0d", i), 16'(bus.nes_data), 16'd0);
    end
    chk("nes_fd_once", 16'(fd_cnt - fd_base), 16'd1);

    // SNES frame, Up, L, R pressed
    bus.buttons   = 12'hC10;
    bus.snes_mode = 1'b1;
    snes_exp = 16'hF3EF;
    fd_base = fd_cnt;
    latch_rise();
    latch_drop();
    bus.snes_mode = 1'b0;
    chk("snes_bit0", 16'(bus.nes_data), 16'(snes_exp[0]));
    for (int i = 1; i < 16; i++) begin
      clk_edge();
      chk($sformatf("snes_bit%0d", i), 16'(bus.nes_data), 16'(snes_exp[i]));
      chk($sformatf("snes_fd%0d", i), 16'(fd_cnt - fd_base), (i == 15) ? 16'd1 : 16'd0);
    end
    clk_edge();
    chk("snes_extra", 16'(bus.nes_data), 16'd0);
    chk("snes_busy_end", 16'(bus.busy), 16'd0);

    // transparent load, then buttons change during SHIFT
    bus.buttons = 12'h000;
    bus.nes_latch = 1'b1;
    wait_cyc(3);
    bus.buttons = 12'h100;
    wait_cyc(6);
    latch_drop();
    chk("tl_bit0", 16'(bus.nes_data), 16'd0);
    bus.buttons = 12'h0FF;
    for (int i = 1; i < 8; i++) begin
      clk_edge();
      chk($sformatf("tl_bit%0d", i), 16'(bus.nes_data), 16'd1);
    end

    // re-latch mid-frame
    bus.buttons = 12'h101;
    fd_base = fd_cnt;
    latch_rise();
    latch_drop();
    for (int i = 1; i < 4; i++) clk_edge();
    chk("rl_bit3", 16'(bus.nes_data), 16'd1);
    chk("rl_busy_pre", 16'(bus.busy), 16'd1);
    bus.buttons = 12'h080;
    latch_rise();
    chk("rl_busy_latch", 16'(bus.busy), 16'd1);
    chk("rl_latch_data", 16'(bus.nes_data), 16'd1);
    latch_drop();
    chk("rl_bit0", 16'(bus.nes_data), 16'd1);
    for (int i = 1; i < 7; i++) begin
      clk_edge();
      chk($sformatf("rl_bit%0d", i), 16'(bus.nes_data), 16'd1);
    end
    chk("rl_no_fd", 16'(fd_cnt - fd_base), 16'd0);
    clk_edge();
    chk("rl_bit7", 16'(bus.nes_data), 16'd0);
    chk("rl_fd", 16'(fd_cnt - fd_base), 16'd1);

    // reset mid-SHIFT
    bus.buttons = 12'h101;
    latch_rise();
    latch_drop();
    clk_edge();
    clk_edge();
    rst_n = 1'b0;
    #1;
    chk("mr_data", 16'(bus.nes_data), 16'd1);
    chk("mr_busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);
    clk_edge();
    clk_edge();
    chk("mr_idle_data", 16'(bus.nes_data), 16'd1);
    chk("mr_idle_state", 16'(dbg_state), 16'd0);

    // coincident latch fall and clock rise, only B pressed
    bus.buttons = 12'h001;
    fd_base = fd_cnt;
    latch_rise();
    bus.nes_latch = 1'b0;
    bus.nes_clk   = 1'b1;
    wait_cyc(5);
    chk("co_bit0", 16'(bus.nes_data), 16'd1);
    bus.nes_clk = 1'b0;
    wait_cyc(5);
    clk_edge();
    chk("co_bit1", 16'(bus.nes_data), 16'd0);
    for (int i = 2; i < 8; i++) begin
      clk_edge();
      chk($sformatf("co_bit%0d", i), 16'(bus.nes_data), 16'd1);
    end
    chk("co_fd", 16'(fd_cnt - fd_base), 16'd1);
    clk_edge();
    chk("co_extra", 16'(bus.nes_data), 16'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
